// File: rtl/flag_seq_ctrl_if.sv
// flag_seq_ctrl_if: groups the decoder/ALU/flag-register signals of the flag sequencer.
//   master : decoder/environment side (drives instruction, flags, stall; observes controls)
//   slave  : flag_seq_ctrl side (observes instruction, flags, stall; drives controls)
// Signals:
//   instr_valid, op_kind[2:0], cond[2:0]  decoded instruction
//   flag_c, flag_z, flag_v, flag_s        committed flags
//   stall                                 freezes sequencing
//   ready, sst[1:0], alu_go               acceptance, flag select, ALU start
//   br_valid, br_taken, done              jump resolution and retire pulse
interface flag_seq_ctrl_if;
  logic       instr_valid;
  logic [2:0] op_kind;
  logic [2:0] cond;
  logic       flag_c;
  logic       flag_z;
  logic       flag_v;
  logic       flag_s;
  logic       stall;
  logic       ready;
  logic [1:0] sst;
  logic       alu_go;
  logic       br_valid;
  logic       br_taken;
  logic       done;

  modport master (
    output instr_valid, op_kind, cond, flag_c, flag_z, flag_v, flag_s, stall,
    input  ready, sst, alu_go, br_valid, br_taken, done
  );

  modport slave (
    input  instr_valid, op_kind, cond, flag_c, flag_z, flag_v, flag_s, stall,
    output ready, sst, alu_go, br_valid, br_taken, done
  );
endinterface

// File: rtl/flag_seq_ctrl.sv
// flag_seq_ctrl: per-instruction sequencer driving the flag-register select (sst) and the ALU
// start strobe, and resolving conditional jumps against the committed flags.
// Ports:
//   i_clk    system clock, all state on the rising edge
//   i_reset  synchronous active-high reset
//   io_bus   flag_seq_ctrl_if.slave (instruction in, flags in, stall in; control outputs)
// Parameter:
//   MULCYC   total execute cycles (EXEC + WAIT) of a multi-cycle ALU op, 2..16
module flag_seq_ctrl #(
  parameter int unsigned MULCYC = 4
) (
  input logic             i_clk,
  input logic             i_reset,
  flag_seq_ctrl_if.slave  io_bus
);

  localparam int unsigned CntW = (MULCYC > 2) ? $clog2(MULCYC) : 1;

  localparam logic [2:0] OpAlu   = 3'b001;
  localparam logic [2:0] OpAluMc = 3'b010;
  localparam logic [2:0] OpClc   = 3'b011;
  localparam logic [2:0] OpStc   = 3'b100;
  localparam logic [2:0] OpJcond = 3'b101;
  localparam logic [2:0] OpAluNf = 3'b110;

  localparam logic [1:0] SstLoad = 2'b00;
  localparam logic [1:0] SstClrC = 2'b01;
  localparam logic [1:0] SstSetC = 2'b10;
  localparam logic [1:0] SstHold = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StWait,
    StFlag,
    StBranch,
    StRetire
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_op;
  logic [2:0]        r_cond;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_nxt;
  logic              w_accept;
  logic              w_cond_met;

  assign w_accept = io_bus.instr_valid && (r_state == StIdle) && !io_bus.stall;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_op    <= 3'b000;
      r_cond  <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_op   <= io_bus.op_kind;
        r_cond <= io_bus.cond;
      end
    end
  end

  // Jump condition against the committed flags.
  always_comb begin
    w_cond_met = 1'b0;
    case (r_cond)
      3'b000:  w_cond_met = 1'b1;
      3'b001:  w_cond_met = io_bus.flag_c;
      3'b010:  w_cond_met = !io_bus.flag_c;
      3'b011:  w_cond_met = io_bus.flag_z;
      3'b100:  w_cond_met = !io_bus.flag_z;
      3'b101:  w_cond_met = io_bus.flag_s;
      3'b110:  w_cond_met = !io_bus.flag_s;
      default: w_cond_met = io_bus.flag_v;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    io_bus.ready    = (r_state == StIdle);
    io_bus.sst      = SstHold;
    io_bus.alu_go   = 1'b0;
    io_bus.done     = 1'b0;
    io_bus.br_valid = 1'b0;
    io_bus.br_taken = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          case (io_bus.op_kind)
            OpAlu, OpAluMc, OpAluNf: w_state_nxt = StExec;
            OpClc, OpStc:            w_state_nxt = StFlag;
            OpJcond:                 w_state_nxt = StBranch;
            default:                 w_state_nxt = StRetire;
          endcase
        end
      end
      StExec: begin
        if (!io_bus.stall) begin
          io_bus.alu_go = 1'b1;
          if (r_op == OpAluMc) begin
            w_state_nxt = StWait;
            // Count MULCYC-1 WAIT cycles down to zero inclusive.
            w_cnt_nxt   = CntW'(MULCYC - 2);
          end else if (r_op == OpAlu) begin
            w_state_nxt = StFlag;
          end else begin
            w_state_nxt = StRetire;
          end
        end
      end
      StWait: begin
        if (!io_bus.stall) begin
          if (r_cnt == '0) begin
            w_state_nxt = StFlag;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      StFlag: begin
        if (!io_bus.stall) begin
          io_bus.done = 1'b1;
          case (r_op)
            OpClc:   io_bus.sst = SstClrC;
            OpStc:   io_bus.sst = SstSetC;
            default: io_bus.sst = SstLoad;
          endcase
          w_state_nxt = StIdle;
        end
      end
      StBranch: begin
        if (!io_bus.stall) begin
          io_bus.br_valid = 1'b1;
          io_bus.br_taken = w_cond_met;
          io_bus.done     = 1'b1;
          w_state_nxt     = StIdle;
        end
      end
      StRetire: begin
        if (!io_bus.stall) begin
          io_bus.done = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_flag_seq_ctrl.sv
// tb_flag_seq_ctrl: directed scenarios plus a randomized run against a phase-list model of
// flag_seq_ctrl. The bench also plays the flag register, reacting to sst at each edge.
module tb_flag_seq_ctrl;

  localparam int unsigned MULCYC = 4;

  logic clk;
  logic reset;
  logic [3:0] flags   = 4'h0;  // {s, v, z, c}
  logic [3:0] alu_res = 4'h0;
  int tests = 0;
  int fails = 0;

  flag_seq_ctrl_if bus ();

  flag_seq_ctrl #(.MULCYC(MULCYC)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  assign bus.flag_c = flags[0];
  assign bus.flag_z = flags[1];
  assign bus.flag_v = flags[2];
  assign bus.flag_s = flags[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag register model driven by the DUT's select.
  always @(posedge clk) begin
    if (!reset) begin
      case (bus.sst)
        2'b00:   flags    <= alu_res;
        2'b01:   flags[0] <= 1'b0;
        2'b10:   flags[0] <= 1'b1;
        default: ;
      endcase
    end
    alu_res <= 4'($urandom);
  end

  // {ready, sst, alu_go, done, br_valid, br_taken}
  wire [6:0] obs = {bus.ready, bus.sst, bus.alu_go, bus.done, bus.br_valid, bus.br_taken};

  function automatic logic [6:0] pk(input logic rdy, input logic [1:0] s, input logic alu,
                                    input logic dn, input logic bv, input logic bt);
    return {rdy, s, alu, dn, bv, bt};
  endfunction

  localparam logic [6:0] Idle = 7'b1_11_0000;
  localparam logic [6:0] Busy = 7'b0_11_0000;

  function automatic logic exp_taken(input logic [2:0] c, input logic [3:0] f);
    case (c)
      3'd0:    return 1'b1;
      3'd1:    return f[0];
      3'd2:    return !f[0];
      3'd3:    return f[1];
      3'd4:    return !f[1];
      3'd5:    return f[3];
      3'd6:    return !f[3];
      default: return f[2];
    endcase
  endfunction

  // Inputs change mid-cycle (negedge); outputs are checked 1 time unit later.
  task automatic set_in(input logic v, input logic [2:0] op, input logic [2:0] c,
                        input logic st);
    bus.instr_valid = v;
    bus.op_kind     = op;
    bus.cond        = c;
    bus.stall       = st;
    #1;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] f0;
    reset = 1'b1;
    set_in(1'b0, 3'd0, 3'd0, 1'b0);
    next();
    next();
    tests++;
    if (obs !== Idle) begin
      fails++;
      $display("FAIL reset_state: got %b expected %b", obs, Idle);
    end
    reset = 1'b0;
    // Multi-cycle op aborted in WAIT.
    set_in(1'b1, 3'b010, 3'd0, 1'b0);
    next();
    set_in(1'b0, 3'd0, 3'd0, 1'b0);
    tests++;
    if (obs !== pk(0, 2'b11, 1, 0, 0, 0)) begin
      fails++;
      $display("FAIL reset_mid_exec: got %b expected %b", obs, pk(0, 2'b11, 1, 0, 0, 0));
    end
    next();
    tests++;
    if (obs !== Busy) begin
      fails++;
      $display("FAIL reset_mid_wait: got %b expected %b", obs, Busy);
    end
    f0    = flags;
    reset = 1'b1;
    next();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (obs !== Idle) begin
        fails++;
        $display("FAIL reset_abort_idle[%0d]: got %b expected %b", i, obs, Idle);
      end
      next();
    end
    tests++;
    if (flags !== f0) begin
      fails++;
      $display("FAIL reset_flags_kept: got %h expected %h", flags, f0);
    end
  endtask

  task automatic test_alu();
    set_in(1'b1, 3'b001, 3'd0, 1'b0);
    tests++;
    if (obs !== Idle) begin
      fails++;
      $display("FAIL alu_accept: got %b expected %b", obs, Idle);
    end
    next();
    set_in(1'b0, 3'd0, 3'd0, 1'b0);
    tests++;
    if (obs !== pk(0, 2'b11, 1, 0, 0, 0)) begin
      fails++;
      $display("FAIL alu_exec: got %b expected %b", obs, pk(0, 2'b11, 1, 0, 0, 0));
    end
    next();
    tests++;
    if (obs !== pk(0, 2'b00, 0, 1, 0, 0)) begin
      fails++;
      $display("FAIL alu_flag: got %b expected %b", obs, pk(0, 2'b00, 0, 1, 0, 0));
    end
    next();
    tests++;
    if (obs !== Idle) begin
      fails++;
      $display("FAIL alu_ready: got %b expected %b", obs, Idle);
    end
  endtask

  task automatic test_mulcyc();
    set_in(1'b1, 3'b010, 3'd0, 1'b0);
    next();
    set_in(1'b0, 3'd0, 3'd0, 1'b0);
    tests++;
    if (obs !== pk(0, 2'b11, 1, 0, 0, 0)) begin
      fails++;
      $display("FAIL mul_exec: got %b expected %b", obs, pk(0, 2'b11, 1, 0, 0, 0));
    end
    for (int i = 0; i < int'(MULCYC) - 1; i++) begin
      next();
      tests++;
      if (obs !== Busy) begin
        fails++;
        $display("FAIL mul_wait[%0d]: got %b expected %b", i, obs, Busy);
      end
    end
    next();
    tests++;
    if (obs !== pk(0, 2'b00, 0, 1, 0, 0)) begin
      fails++;
      $display("FAIL mul_flag: got %b expected %b", obs, pk(0, 2'b00, 0, 1, 0, 0));
    end
    next();
    tests++;
    if (obs !== Idle) begin
      fails++;
      $display("FAIL mul_ready: got %b expected %b", obs, Idle);
    end
  endtask

  task automatic test_branch();
    set_in(1'b1, 3'b100, 3'd0, 1'b0);
    next();
    set_in(1'b0, 3'd0, 3'd0, 1'b0);
    tests++;
    if (obs !== pk(0, 2'b10, 0, 1, 0, 0)) begin
      fails++;
      $display("FAIL stc_flag: got %b expected %b", obs, pk(0, 2'b10, 0, 1, 0, 0));
    end
    next();
    set_in(1'b1, 3'b101, 3'b001, 1'b0);
    tests++;
    if (flags[0] !== 1'b1) begin
      fails++;
      $display("FAIL stc_sets_c: got %b expected 1", flags[0]);
    end
    next();
    set_in(1'b0, 3'd0, 3'd0, 1'b0);
    tests++;
    if (obs !== pk(0, 2'b11, 0, 1, 1, 1)) begin
      fails++;
      $display("FAIL jc_taken: got %b expected %b", obs, pk(0, 2'b11, 0, 1, 1, 1));
    end
    next();
    set_in(1'b1, 3'b101, 3'b010, 1'b0);
    next();
    set_in(1'b0, 3'd0, 3'd0, 1'b0);
    tests++;
    if (obs !== pk(0, 2'b11, 0, 1, 1, 0)) begin
      fails++;
      $display("FAIL jnc_not_taken: got %b expected %b", obs, pk(0, 2'b11, 0, 1, 1, 0));
    end
    next();
  endtask

  task automatic test_stall();
    // Stall in IDLE only blocks acceptance.
    set_in(1'b1, 3'b001, 3'd0, 1'b1);
    tests++;
    if (obs !== Idle) begin
      fails++;
      $display("FAIL stall_idle_ready: got %b expected %b", obs, Idle);
    end
    next();
    set_in(1'b1, 3'b001, 3'd0, 1'b0);
    tests++;
    if (obs !== Idle) begin
      fails++;
      $display("FAIL stall_idle_block: got %b expected %b", obs, Idle);
    end
    next();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 3'd0, 3'd0, 1'b1);
      tests++;
      if (obs !== Busy) begin
        fails++;
        $display("FAIL stall_exec_hold[%0d]: got %b expected %b", i, obs, Busy);
      end
      next();
    end
    set_in(1'b0, 3'd0, 3'd0, 1'b0);
    tests++;
    if (obs !== pk(0, 2'b11, 1, 0, 0, 0)) begin
      fails++;
      $display("FAIL stall_release_alu: got %b expected %b", obs, pk(0, 2'b11, 1, 0, 0, 0));
    end
    next();
    tests++;
    if (obs !== pk(0, 2'b00, 0, 1, 0, 0)) begin
      fails++;
      $display("FAIL stall_flag_once: got %b expected %b", obs, pk(0, 2'b00, 0, 1, 0, 0));
    end
    next();
    tests++;
    if (obs !== Idle) begin
      fails++;
      $display("FAIL stall_retired: got %b expected %b", obs, Idle);
    end
  endtask

  task automatic test_retire_ops();
    set_in(1'b1, 3'b110, 3'd0, 1'b0);
    next();
    set_in(1'b0, 3'd0, 3'd0, 1'b0);
    tests++;
    if (obs !== pk(0, 2'b11, 1, 0, 0, 0)) begin
      fails++;
      $display("FAIL nf_exec: got %b expected %b", obs, pk(0, 2'b11, 1, 0, 0, 0));
    end
    next();
    tests++;
    if (obs !== pk(0, 2'b11, 0, 1, 0, 0)) begin
      fails++;
      $display("FAIL nf_retire: got %b expected %b", obs, pk(0, 2'b11, 0, 1, 0, 0));
    end
    next();
    set_in(1'b1, 3'b111, 3'd0, 1'b0);
    next();
    set_in(1'b0, 3'd0, 3'd0, 1'b0);
    tests++;
    if (obs !== pk(0, 2'b11, 0, 1, 0, 0)) begin
      fails++;
      $display("FAIL rsv_retire: got %b expected %b", obs, pk(0, 2'b11, 0, 1, 0, 0));
    end
    next();
    tests++;
    if (obs !== Idle) begin
      fails++;
      $display("FAIL rsv_idle: got %b expected %b", obs, Idle);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp;
    for (int i = 0; i < 9; i++) begin
      set_in(1'b1, 3'b001, 3'd0, 1'b0);
      case (i % 3)
        0:       exp = Idle;
        1:       exp = pk(0, 2'b11, 1, 0, 0, 0);
        default: exp = pk(0, 2'b00, 0, 1, 0, 0);
      endcase
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL b2b[%0d]: got %b expected %b", i, obs, exp);
      end
      next();
    end
    set_in(1'b0, 3'd0, 3'd0, 1'b0);
    next();
  endtask

  // Reference model: each accepted instruction expands into its list of per-cycle outputs.
  typedef struct packed {
    logic       alu;
    logic [1:0] sst;
    logic       done;
    logic       brv;
    logic [2:0] cond;
  } phase_t;

  phase_t q[$];

  function automatic phase_t ph(input logic alu, input logic [1:0] s, input logic dn,
                                input logic bv, input logic [2:0] c);
    return '{alu: alu, sst: s, done: dn, brv: bv, cond: c};
  endfunction

  task automatic push_instr(input logic [2:0] op, input logic [2:0] c);
    case (op)
      3'b001: begin
        q.push_back(ph(1, 2'b11, 0, 0, c));
        q.push_back(ph(0, 2'b00, 1, 0, c));
      end
      3'b010: begin
        q.push_back(ph(1, 2'b11, 0, 0, c));
        for (int k = 0; k < int'(MULCYC) - 1; k++) q.push_back(ph(0, 2'b11, 0, 0, c));
        q.push_back(ph(0, 2'b00, 1, 0, c));
      end
      3'b011: q.push_back(ph(0, 2'b01, 1, 0, c));
      3'b100: q.push_back(ph(0, 2'b10, 1, 0, c));
      3'b101: q.push_back(ph(0, 2'b11, 1, 1, c));
      3'b110: begin
        q.push_back(ph(1, 2'b11, 0, 0, c));
        q.push_back(ph(0, 2'b11, 1, 0, c));
      end
      default: q.push_back(ph(0, 2'b11, 1, 0, c));
    endcase
  endtask

  task automatic test_random();
    logic       v;
    logic       st;
    logic [2:0] op;
    logic [2:0] c;
    logic [6:0] exp;
    phase_t     p;
    q.delete();
    for (int n = 0; n < 600; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 4) == 0);
      op = 3'($urandom);
      c  = 3'($urandom);
      set_in(v, op, c, st);
      if (q.size() == 0) begin
        exp = Idle;
      end else if (st) begin
        exp = Busy;
      end else begin
        p   = q[0];
        exp = pk(0, p.sst, p.alu, p.done, p.brv, p.brv ? exp_taken(p.cond, flags) : 1'b0);
      end
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL random[%0d]: got %b expected %b", n, obs, exp);
      end
      if (q.size() == 0) begin
        if (v && !st) push_instr(op, c);
      end else if (!st) begin
        void'(q.pop_front());
      end
      next();
    end
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.op_kind     = 3'd0;
    bus.cond        = 3'd0;
    bus.stall       = 1'b0;
    reset           = 1'b1;
    @(negedge clk);
    test_reset();
    test_alu();
    test_mulcyc();
    test_branch();
    test_stall();
    test_retire_ops();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
